// File: rtl/data_path_seq_pkg.sv
// data_path_seq_pkg
//   Shared constants and types for the data_path run-time sequencer.
//   Holds the datapath geometry, the PE latencies, the derived
//   pipeline latency / per-stage tap offsets and the sequencer state
//   encoding.
package data_path_seq_pkg;

    localparam int num_col      = 6;
    localparam int n_rf         = num_col - 1;
    localparam int dwidth_int   = 64;
    localparam int dwidth_RFadd = 4;

    localparam int latencyPEA   = 3;
    localparam int latencyPEB   = 2;
    localparam int latencyPEC   = 4;
    localparam int latencyPED   = 5;

    // Issue counter / beat index width.
    localparam int cnt_w        = 32;
    // One tap carries {valid, last, index}.
    localparam int tap_w        = 2 + cnt_w;
    localparam int vld_b        = tap_w - 1;
    localparam int last_b       = tap_w - 2;

    // End-to-end latency of the six-column pipeline.
    function automatic int calc_lat();
        calc_lat = 2*latencyPEA + latencyPEB + 2*latencyPEC + latencyPED;
    endfunction

    localparam int LAT = calc_lat();

    // Cycle at which a beat enters the PE feeding RF slot k.
    function automatic int stage_off(input int k);
        int r;
        case (k)
            0:       r = 0;
            1:       r = latencyPEA;
            2:       r = 2*latencyPEA + latencyPEB;
            3:       r = 2*latencyPEA + latencyPEB + latencyPEC;
            default: r = 2*latencyPEA + latencyPEB + 2*latencyPEC;
        endcase
        stage_off = r;
    endfunction

    // Cycle at which the result for RF slot k is ready to be written.
    function automatic int wen_off(input int k);
        int r;
        case (k)
            0:       r = latencyPEA;
            1:       r = 2*latencyPEA;
            2:       r = 2*latencyPEA + latencyPEB + latencyPEC;
            3:       r = 2*latencyPEA + latencyPEB + 2*latencyPEC;
            default: r = calc_lat();
        endcase
        wen_off = r;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

    typedef struct packed {
        logic             valid;
        logic             last;
        logic [cnt_w-1:0] idx;
    } beat_t;

endpackage

// File: rtl/data_path_seq_tap_line.sv
// valid_tap_line
//   Delay line tracking beats through the datapath pipeline.
//   taps[0] is the live input, taps[d] is the input delayed by d cycles.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low clear of every stage
//   din  - beat entering the pipeline this cycle
//   taps - all DEPTH+1 taps, tap 0 = din
module valid_tap_line
    import data_path_seq_pkg::*;
#(
    parameter int W     = tap_w,
    parameter int DEPTH = LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          din,
    output logic [DEPTH:0][W-1:0] taps
);

    logic [DEPTH:1][W-1:0] line;

    always_ff @(posedge clk) begin
        if (!rst) begin
            line <= '0;
        end else begin
            line[1] <= din;
            for (int i = 2; i <= DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign taps = {line, din};

endmodule

// File: rtl/data_path_seq.sv
// data_path_seq
//   Run-time sequencer for the six-column SIMD data_path. Latches a
//   kernel configuration on start, accepts num_itr beats through a
//   valid/ready handshake, tracks every beat through the fixed-latency
//   pipeline and drives per-column iteration indices, RF write enables
//   and the output valid/last flags.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   start, cfg_*      - kernel launch and its configuration
//   in_valid/in_ready - input beat handshake
//   sel_mux4, op, isItr, rd_addr_RF, wr_addr_RF - latched config to data_path
//   wen_RF            - RF write enables aligned to each beat
//   itr               - per-column iteration index (slot k at [k*64 +: 64])
//   out_valid/out_last- stream_out beat qualifiers
//   busy, done        - status; done pulses for one cycle per kernel
module data_path_seq
    import data_path_seq_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [31:0]                     cfg_num_itr,
    input  logic [num_col*4-1:0]            cfg_sel_mux4,
    input  logic [num_col*2-1:0]            cfg_op,
    input  logic [n_rf-1:0]                 cfg_wen,
    input  logic [n_rf-1:0]                 cfg_isItr,
    input  logic [dwidth_RFadd*n_rf-1:0]    cfg_rd_addr,
    input  logic [dwidth_RFadd*n_rf-1:0]    cfg_wr_addr,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [num_col*4-1:0]            sel_mux4,
    output logic [num_col*2-1:0]            op,
    output logic [n_rf-1:0]                 isItr,
    output logic [dwidth_RFadd*n_rf-1:0]    rd_addr_RF,
    output logic [dwidth_RFadd*n_rf-1:0]    wr_addr_RF,
    output logic [num_col-1:0]              wen_RF,
    output logic [n_rf*dwidth_int-1:0]      itr,
    output logic                            out_valid,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);

    seq_state_t                        state;
    logic [cnt_w-1:0]                  num_itr_r;
    logic [cnt_w-1:0]                  issue_cnt;
    logic [n_rf-1:0]                   wen_r;
    logic                              issue;
    logic                              issue_last;
    beat_t                             beat_in;
    logic [LAT:0][tap_w-1:0]           taps;
    logic [n_rf-1:0][dwidth_int-1:0]   itr_hold;
    logic [n_rf-1:0][dwidth_int-1:0]   itr_next;
    logic                              unused_taps;

    assign issue      = in_ready & in_valid;
    assign issue_last = (issue_cnt == num_itr_r - 32'd1);
    assign busy       = (state != IDLE);

    always_comb begin
        beat_in.valid = issue;
        beat_in.last  = issue & issue_last;
        beat_in.idx   = issue_cnt;
    end

    // Control FSM: launch, issue counting, drain and completion pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            done       <= 1'b0;
            issue_cnt  <= '0;
            num_itr_r  <= '0;
            wen_r      <= '0;
            sel_mux4   <= '0;
            op         <= '0;
            isItr      <= '0;
            rd_addr_RF <= '0;
            wr_addr_RF <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_itr_r  <= cfg_num_itr;
                        wen_r      <= cfg_wen;
                        sel_mux4   <= cfg_sel_mux4;
                        op         <= cfg_op;
                        isItr      <= cfg_isItr;
                        rd_addr_RF <= cfg_rd_addr;
                        wr_addr_RF <= cfg_wr_addr;
                        issue_cnt  <= '0;
                        if (cfg_num_itr != 32'd0) begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        issue_cnt <= issue_cnt + 32'd1;
                        if (issue_last) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid & out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    valid_tap_line #(
        .W     (tap_w),
        .DEPTH (LAT)
    ) u_tap_line (
        .clk  (clk),
        .rst  (rst),
        .din  (beat_in),
        .taps (taps)
    );

    // Most intermediate taps only feed the next stage of the line.
    assign unused_taps = ^taps;

    // Slot k follows the beat entering its PE; it holds between beats.
    for (genvar k = 0; k < n_rf; k++) begin : g_slot
        localparam int sk = stage_off(k);
        localparam int ek = wen_off(k);

        assign itr_next[k] = taps[sk][vld_b]
                           ? {{(dwidth_int-cnt_w){1'b0}}, taps[sk][cnt_w-1:0]}
                           : itr_hold[k];
        assign wen_RF[k]   = wen_r[k] & taps[ek][vld_b];
    end

    assign wen_RF[num_col-1] = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            itr_hold <= '0;
        end else begin
            itr_hold <= itr_next;
        end
    end

    assign itr       = itr_next;
    assign out_valid = taps[LAT][vld_b];
    assign out_last  = taps[LAT][last_b];

endmodule
